// File: rtl/lab4_pkg.sv
// Shared types and constants for the 7-input exhaustive sweep tester.
package lab4_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int VEC_W = 7;
   localparam int SIG_W = 16;
   localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
   localparam int NUM_VEC = 1 << VEC_W;

   // One MISR step: shift left, fold in the polynomial on carry-out, xor the new bit into bit 0.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic b);
      return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0) ^ {{(SIG_W-1){1'b0}}, b};
   endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; clear reloads the seed, en absorbs one din bit.
module misr16
   import lab4_pkg::*;
#(
   parameter logic [SIG_W-1:0] RST_VAL = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             din,
   input  logic [SIG_W-1:0] seed,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = seed;
      end else if (en) begin
         sig_d = misr_step(sig_q, din);
      end
   end

   // Reset value is a constant so the async reset never depends on a port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= RST_VAL;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/lab4_sweep_tester.sv
// Walks all 128 input vectors of a 7-input function, counting ones and compressing
// the returned bits into a MISR signature.
module lab4_sweep_tester
   import lab4_pkg::*;
#(
   parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        e,
   output logic        f,
   output logic        g,
   input  logic        f_in,
   output logic        busy,
   output logic        done,
   output logic [7:0]  ones_count,
   output logic [15:0] signature
);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] idx_q, idx_d;
   logic [7:0]       ones_q, ones_d;
   logic             sig_clear;
   logic             sig_en;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ones_d    = ones_q;
      sig_clear = 1'b0;
      sig_en    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = SWEEP;
               idx_d     = '0;
               ones_d    = '0;
               sig_clear = 1'b1;
            end
         end
         SWEEP: begin
            sig_en = 1'b1;
            ones_d = ones_q + {7'b0, f_in};
            idx_d  = idx_q + 7'd1;
            if (idx_q == 7'(NUM_VEC - 1)) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ones_q  <= ones_d;
      end
   end

   misr16 #(
      .RST_VAL (SIG_SEED)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (sig_clear),
      .en    (sig_en),
      .din   (f_in),
      .seed  (SIG_SEED),
      .sig   (signature)
   );

   // Vector bits are gated by the registered state so nothing leaks outside a sweep.
   assign {g, f, e, d, c, b, a} = (state_q == SWEEP) ? idx_q : '0;
   assign busy       = (state_q == SWEEP);
   assign done       = (state_q == DONE);
   assign ones_count = ones_q;

endmodule

// File: tb/tb_lab4_sweep_tester.sv
// Self-checking bench: the downstream minterm block is modelled as a 128-entry truth table.
module tb_lab4_sweep_tester;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        a, b, c, d, e, f, g;
   logic        f_in;
   logic        busy, done;
   logic [7:0]  ones_count;
   logic [15:0] signature;

   logic [127:0] tt;
   logic [6:0]   vec;

   int check_cnt = 0;
   int pass_cnt  = 0;

   assign vec  = {g, f, e, d, c, b, a};
   assign f_in = tt[vec];

   lab4_sweep_tester #(.SIG_SEED(16'hFFFF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .e          (e),
      .f          (f),
      .g          (g),
      .f_in       (f_in),
      .busy       (busy),
      .done       (done),
      .ones_count (ones_count),
      .signature  (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] tt;
      int           exp_ones;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input longint act, input longint exp);
      check_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: popcount of the table and the signature of its bits in vector order.
   task automatic model(input logic [127:0] t, output int ones, output logic [15:0] sig);
      logic [16:0] tmp;
      ones = 0;
      sig  = 16'hFFFF;
      for (int i = 0; i < 128; i++) begin
         ones += int'(t[i]);
         tmp = {sig, 1'b0};
         sig = tmp[15:0] ^ (tmp[16] ? 16'h1021 : 16'h0000) ^ {15'b0, t[i]};
      end
   endtask

   // Entered on a negedge; returns on the first negedge where done is high.
   task automatic wait_done(output int cyc, output int vec_err);
      cyc = 0;
      vec_err = 0;
      while (!done && cyc < 400) begin
         if (busy) begin
            if (vec != cyc[6:0]) vec_err++;
            cyc++;
         end
         @(negedge clk);
      end
      if (!done) begin
         $display("FAIL done_timeout: got done=%0b expected 1", done);
         check_cnt++;
      end
   endtask

   task automatic run_sweep(input string name, input logic [127:0] t, input int exp_ones);
      int cyc, verr, m_ones;
      logic [15:0] m_sig;
      model(t, m_ones, m_sig);
      tt = t;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({name, "_busy_start"}, {busy, done}, 2'b10);
      wait_done(cyc, verr);
      check({name, "_busy_cycles"}, cyc, 128);
      check({name, "_vec_walk"}, verr, 0);
      check({name, "_ones"}, ones_count, m_ones);
      check({name, "_sig"}, signature, m_sig);
      check({name, "_vec_zero_done"}, vec, 0);
      if (exp_ones >= 0) check({name, "_ones_table"}, ones_count, exp_ones);
      $display("sweep %s: ones=%0d sig=%04h cycles=%0d", name, ones_count, signature, cyc);
   endtask

   initial begin
      logic [127:0] t;
      int ones1, m_ones, cyc, verr, bound;
      logic [15:0] sig1, m_sig;

      tbl[0] = '{"zero", '0, 0};
      tbl[1] = '{"one", '1, 128};
      t = '0; for (int i = 0; i < 128; i++) t[i] = i[0];
      tbl[2] = '{"eq_a", t, 64};
      t = '0; t[127] = 1'b1;
      tbl[3] = '{"and7", t, 1};
      tbl[4] = '{"minterm_blk", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64};

      rst_n = 1'b0;
      start = 1'b0;
      tt    = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, vec, ones_count, signature}, {2'b00, 7'd0, 8'd0, 16'hFFFF});
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_hold", {busy, done, vec}, 9'd0);

      for (int i = 0; i < 5; i++) run_sweep(tbl[i].name, tbl[i].tt, tbl[i].exp_ones);

      // Results must hold through DONE while start stays low.
      ones1 = ones_count; sig1 = signature;
      repeat (5) @(negedge clk);
      check("done_hold", {done, ones_count, signature}, {1'b1, ones1[7:0], sig1});

      for (int r = 0; r < 4; r++) begin
         t = {$urandom, $urandom, $urandom, $urandom};
         run_sweep($sformatf("rand%0d", r), t, -1);
      end

      // start held high: one sweep per DONE visit, identical results back to back.
      t = {$urandom, $urandom, $urandom, $urandom};
      model(t, m_ones, m_sig);
      tt = t;
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      wait_done(cyc, verr);
      check("held1_cycles", cyc, 128);
      ones1 = ones_count; sig1 = signature;
      check("held1_ones", ones_count, m_ones);
      check("held1_sig", signature, m_sig);
      @(negedge clk);
      check("held_restart", {busy, done}, 2'b10);
      wait_done(cyc, verr);
      start = 1'b0;
      check("held2_cycles", cyc, 128);
      check("held2_same", {ones_count, signature}, {ones1[7:0], sig1});
      @(negedge clk);
      check("held_stop", {busy, done}, 2'b01);
      $display("sweep held: ones=%0d sig=%04h", ones_count, signature);

      // Reset in the middle of a sweep at idx=50.
      t = {$urandom, $urandom, $urandom, $urandom};
      tt = t;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      bound = 0;
      while (!(busy && vec == 7'd50) && bound < 200) begin
         @(negedge clk);
         bound++;
      end
      check("reach_idx50", vec, 50);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {busy, done, vec, ones_count, signature}, {2'b00, 7'd0, 8'd0, 16'hFFFF});
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", {busy, done}, 2'b00);
      run_sweep("after_reset", t, -1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
